// File: rtl/adc_sample_source_if.sv
// Request/ready sample bus between a capture controller (master) and the ADC front-end (slave).
interface adc_sample_source_if;
  logic       req;
  logic       rdy;
  logic [7:0] dat;

  modport master (
    output req,
    input  rdy,
    input  dat
  );

  modport slave (
    input  req,
    output rdy,
    output dat
  );
endinterface

// File: rtl/adc_sample_source.sv
// ADC front-end serving deterministic sawtooth samples over a 4-phase req/rdy handshake.
// Optional dither: define ADC_NOISE_EN to XOR two LFSR bits into each delivered sample.
module adc_sample_source #(
  parameter int         CONV_CYCLES = 4,
  parameter logic [7:0] SEED        = 8'h00,
  parameter logic [7:0] STEP        = 8'd13
) (
  input logic                clk,
  input logic                reset,
  adc_sample_source_if.slave bus
);

  localparam int C_EFF = (CONV_CYCLES < 1) ? 1 : CONV_CYCLES;
  localparam int CNT_W = (C_EFF > 1) ? $clog2(C_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(C_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_READY
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_sample;
  logic [7:0]       w_sample_nxt;
  logic [7:0]       r_dat;
  logic [7:0]       w_dat_nxt;
  logic             r_rdy;
  logic             w_rdy_nxt;
  logic [7:0]       w_conv_val;
  logic             w_complete;

`ifdef ADC_NOISE_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_nxt;
  logic       w_lfsr_fb;

  // Fibonacci taps 8,6,5,4; the pre-advance value dithers the sample being delivered.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsr_nxt = w_complete ? {r_lfsr[6:0], w_lfsr_fb} : r_lfsr;
  assign w_conv_val = r_sample ^ {6'b0, r_lfsr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_conv_val = r_sample;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sample_nxt = r_sample;
    w_dat_nxt    = r_dat;
    w_rdy_nxt    = r_rdy;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy_nxt = 1'b0;
        if (bus.req) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_CONVERT: begin
        // Dropping req mid-conversion abandons it without consuming a sample.
        if (!bus.req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_complete   = 1'b1;
          w_dat_nxt    = w_conv_val;
          w_rdy_nxt    = 1'b1;
          w_sample_nxt = r_sample + STEP;
          w_state_nxt  = S_READY;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_READY: begin
        if (!bus.req) begin
          w_rdy_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rdy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sample <= SEED;
      r_dat    <= '0;
      r_rdy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sample <= w_sample_nxt;
      r_dat    <= w_dat_nxt;
      r_rdy    <= w_rdy_nxt;
    end
  end

  assign bus.rdy = r_rdy;
  assign bus.dat = r_dat;

endmodule

// File: tb/tb_adc_sample_source.sv
// Directed self-checking bench for adc_sample_source with default parameters (no dither).
module tb_adc_sample_source;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  adc_sample_source_if bus_if ();

  adc_sample_source #(
    .CONV_CYCLES(4),
    .SEED       (8'h00),
    .STEP       (8'd13)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed sawtooth: k*13 mod 256 for k = 0..23.
  logic [7:0] exp_seq [0:23] = '{
    8'h00, 8'h0D, 8'h1A, 8'h27, 8'h34, 8'h41, 8'h4E, 8'h5B,
    8'h68, 8'h75, 8'h82, 8'h8F, 8'h9C, 8'hA9, 8'hB6, 8'hC3,
    8'hD0, 8'hDD, 8'hEA, 8'hF7, 8'h04, 8'h11, 8'h1E, 8'h2B
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One handshake from IDLE; req is raised just before the next edge, so rdy must
  // appear after the fifth edge. hold = extra cycles req stays high once rdy is seen.
  task automatic handshake(input string tag, input logic [7:0] exp, input int hold);
    int edges;
    edges = 0;
    bus_if.req = 1'b1;
    while (bus_if.rdy !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat"}, edges, 5);
    check({tag, "_dat"}, bus_if.dat, exp);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_rdy"}, bus_if.rdy, 1'b1);
      check({tag, "_hold_dat"}, bus_if.dat, exp);
    end
    bus_if.req = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_fall"}, bus_if.rdy, 1'b0);
    check({tag, "_dat_keep"}, bus_if.dat, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus_if.req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rdy", bus_if.rdy, 1'b0);
      check("idle_dat", bus_if.dat, 8'h00);
    end

    // Full sequence including the 0xD0 boundary and the wrap to 0x04.
    for (int unsigned k = 0; k <= 20; k++) begin
      handshake($sformatf("seq%0d", k), exp_seq[k], 0);
    end

    // Abort after two edges: no rdy, dat and sample untouched.
    bus_if.req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_rdy_conv", bus_if.rdy, 1'b0);
    end
    bus_if.req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_rdy", bus_if.rdy, 1'b0);
      check("abort_dat", bus_if.dat, 8'h04);
    end
    handshake("after_abort", exp_seq[21], 0);

    // req held after rdy: single delivery, then the next value follows.
    handshake("held", exp_seq[22], 10);
    handshake("after_held", exp_seq[23], 0);

    // Reset during CONVERT.
    bus_if.req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_conv_rdy", bus_if.rdy, 1'b0);
    check("rst_conv_dat", bus_if.dat, 8'h00);
    bus_if.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    handshake("post_rst_conv", exp_seq[0], 0);

    // Reset while READY with req still high.
    handshake("pre_rst_ready", exp_seq[1], 0);
    bus_if.req = 1'b1;
    begin
      int edges;
      edges = 0;
      while (bus_if.rdy !== 1'b1 && edges < 20) begin
        @(negedge clk);
        edges++;
      end
      check("rdy_before_rst", bus_if.rdy, 1'b1);
      check("dat_before_rst", bus_if.dat, exp_seq[2]);
    end
    reset = 1'b1;
    #1;
    check("rst_ready_rdy", bus_if.rdy, 1'b0);
    check("rst_ready_dat", bus_if.dat, 8'h00);
    bus_if.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    handshake("post_rst_ready", exp_seq[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
